// File: rtl/decode_pkg.sv
// decode_pkg
// Shared types and helpers for the IF/ID stage and later decode consumers.
//   imm_src_e      : immediate-select code seen by the immediate generator
//   state_e        : occupancy of the IF/ID skid buffer
//   if_entry_t     : one buffered fetch {instr, pc}
//   dec_t          : opcode decode result {imm_src, has_imm, illegal}
//   decode_opcode  : opcode -> dec_t
// Build option: DECODE_ILLEGAL_TRAP_EN makes decode_opcode flag unknown
// opcodes and non-32-bit encodings (instr[1:0] != 2'b11) as illegal;
// without it, illegal is always 0.
package decode_pkg;

  localparam int PKG_XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_U = 3'b010,
    IMM_B = 3'b101,
    IMM_J = 3'b110
  } imm_src_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [PKG_XLEN-1:0] instr;
    logic [PKG_XLEN-1:0] pc;
  } if_entry_t;

  typedef struct packed {
    imm_src_e imm_src;
    logic     has_imm;
    logic     illegal;
  } dec_t;

  function automatic dec_t decode_opcode(input logic [6:0] opcode);
    dec_t d;
    d.imm_src = IMM_I;
    d.has_imm = 1'b0;
    d.illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: d.has_imm = 1'b1;
      OPC_STORE: begin
        d.imm_src = IMM_S;
        d.has_imm = 1'b1;
      end
      OPC_BRANCH: begin
        d.imm_src = IMM_B;
        d.has_imm = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        d.imm_src = IMM_U;
        d.has_imm = 1'b1;
      end
      OPC_JAL: begin
        d.imm_src = IMM_J;
        d.has_imm = 1'b1;
      end
      OPC_OP: d.has_imm = 1'b0;
      default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        d.illegal = 1'b1;
`endif
      end
    endcase
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (opcode[1:0] != 2'b11) d.illegal = 1'b1;
`endif
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_opcode_decoder.sv
// opcode_decoder
// Combinational opcode decode, shared with later pipeline stages.
// Ports:
//   opcode  in  7  instr[6:0]
//   imm_src out 3  immediate select code
//   has_imm out 1  instruction carries an immediate
//   illegal out 1  unknown/non-32-bit opcode (only with DECODE_ILLEGAL_TRAP_EN)
module opcode_decoder
  import decode_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_src,
  output logic       has_imm,
  output logic       illegal
);

  dec_t dec;

  always_comb begin
    dec     = decode_opcode(opcode);
    imm_src = dec.imm_src;
    has_imm = dec.has_imm;
    illegal = dec.illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// IF/ID pipeline register built as a 2-entry skid buffer, with opcode
// decode of the presented (main) entry for the immediate generator.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous kill of all buffered instructions
//   if_valid/if_ready     upstream handshake (if_ready is registered)
//   if_instr, if_pc       fetched instruction and its PC
//   id_valid/id_ready     downstream handshake
//   id_imm_inst           instr[31:7] for the immediate generator
//   id_imm_src, id_has_imm, id_illegal   decode of the main entry
//   id_opcode, id_rd, id_rs1, id_rs2, id_funct3, id_pc   main entry fields
// Build option: DECODE_ILLEGAL_TRAP_EN adds illegal detection and holds
// if_ready low while an illegal instruction is presented.
//
// state    | meaning
// ST_EMPTY | no entries, id_* show NOP_INSTR decode
// ST_ONE   | main entry valid
// ST_TWO   | main and skid entries valid, upstream stalled
module decode_stage
  import decode_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [24:0]     id_imm_inst,
  output logic [2:0]      id_imm_src,
  output logic            id_has_imm,
  output logic [6:0]      id_opcode,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [2:0]      id_funct3,
  output logic [XLEN-1:0] id_pc,
  output logic            id_illegal
);

  localparam if_entry_t NOP_ENTRY = '{instr: NOP_INSTR, pc: '0};

  state_e    state_q, state_d;
  if_entry_t main_q, main_d;
  if_entry_t skid_q, skid_d;
  logic      if_ready_q, if_ready_d;
  logic      xfer_in, xfer_out;
`ifdef DECODE_ILLEGAL_TRAP_EN
  dec_t      next_dec;
`endif

  assign xfer_in  = if_valid && if_ready_q;
  assign xfer_out = (state_q != ST_EMPTY) && id_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // A concurrent transfer-out has already been consumed downstream;
      // a concurrent transfer-in is simply dropped.
      state_d = ST_EMPTY;
      main_d  = NOP_ENTRY;
      skid_d  = NOP_ENTRY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (xfer_in) begin
            state_d = ST_ONE;
            main_d  = '{instr: if_instr, pc: if_pc};
          end
        end
        ST_ONE: begin
          if (xfer_in && xfer_out) begin
            main_d = '{instr: if_instr, pc: if_pc};
          end else if (xfer_in) begin
            state_d = ST_TWO;
            skid_d  = '{instr: if_instr, pc: if_pc};
          end else if (xfer_out) begin
            state_d = ST_EMPTY;
            main_d  = NOP_ENTRY;
          end
        end
        ST_TWO: begin
          // if_ready is low here, so only a drain can happen.
          if (xfer_out) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_ENTRY;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_ENTRY;
          skid_d  = NOP_ENTRY;
        end
      endcase
    end

    // Ready is computed from next-cycle occupancy so that the output is a
    // plain flop with no path from id_ready.
    if_ready_d = (state_d != ST_TWO);
`ifdef DECODE_ILLEGAL_TRAP_EN
    next_dec = decode_opcode(main_d.instr[6:0]);
    if ((state_d != ST_EMPTY) && next_dec.illegal) if_ready_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= NOP_ENTRY;
      skid_q     <= NOP_ENTRY;
      if_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      if_ready_q <= if_ready_d;
    end
  end

  opcode_decoder u_opcode_decoder (
    .opcode  (main_q.instr[6:0]),
    .imm_src (id_imm_src),
    .has_imm (id_has_imm),
    .illegal (id_illegal)
  );

  assign if_ready    = if_ready_q;
  assign id_valid    = (state_q != ST_EMPTY);
  assign id_imm_inst = main_q.instr[31:7];
  assign id_opcode   = main_q.instr[6:0];
  assign id_rd       = main_q.instr[11:7];
  assign id_funct3   = main_q.instr[14:12];
  assign id_rs1      = main_q.instr[19:15];
  assign id_rs2      = main_q.instr[24:20];
  assign id_pc       = main_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_valid;
  logic        id_ready;
  logic [24:0] id_imm_inst;
  logic [2:0]  id_imm_src;
  logic        id_has_imm;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [2:0]  id_funct3;
  logic [31:0] id_pc;
  logic        id_illegal;

  int checks;
  int failures;

  decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_imm_inst (id_imm_inst),
    .id_imm_src  (id_imm_src),
    .id_has_imm  (id_has_imm),
    .id_opcode   (id_opcode),
    .id_rd       (id_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_funct3   (id_funct3),
    .id_pc       (id_pc),
    .id_illegal  (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sweep_instr [6];
  logic [2:0]  sweep_src   [6];
  logic        sweep_has   [6];
  logic [6:0]  legal_ops   [10];

  initial begin
    logic [31:0] q_instr [$];
    logic [31:0] q_pc    [$];
    logic [31:0] rnd;
    logic [31:0] exp_i;
    logic [31:0] exp_p;
    logic [31:0] held_i;
    logic [31:0] held_p;
    logic        held;
    int          sent;
    int          recvd;
    int          cycles;

    checks   = 0;
    failures = 0;

    sweep_instr[0] = 32'h1234_50B7; sweep_src[0] = 3'b010; sweep_has[0] = 1'b1; // lui
    sweep_instr[1] = 32'h0020_81B3; sweep_src[1] = 3'b000; sweep_has[1] = 1'b0; // add
    sweep_instr[2] = 32'h0000_1117; sweep_src[2] = 3'b010; sweep_has[2] = 1'b1; // auipc
    sweep_instr[3] = 32'h0000_A103; sweep_src[3] = 3'b000; sweep_has[3] = 1'b1; // lw
    sweep_instr[4] = 32'h0000_80E7; sweep_src[4] = 3'b000; sweep_has[4] = 1'b1; // jalr
    sweep_instr[5] = 32'h0000_0073; sweep_src[5] = 3'b000; sweep_has[5] = 1'b1; // ecall

    legal_ops[0] = 7'b0000011; legal_ops[1] = 7'b0010011;
    legal_ops[2] = 7'b1100111; legal_ops[3] = 7'b1110011;
    legal_ops[4] = 7'b0100011; legal_ops[5] = 7'b1100011;
    legal_ops[6] = 7'b0110111; legal_ops[7] = 7'b0010111;
    legal_ops[8] = 7'b1101111; legal_ops[9] = 7'b0110011;

    rst_n    = 1'b1;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_instr = NOP;
    if_pc    = 32'h0;
    id_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_if_ready", {31'b0, if_ready}, 32'd1);
    check("rst_imm_src", {29'b0, id_imm_src}, 32'd0);
    check("rst_has_imm", {31'b0, id_has_imm}, 32'd1);
    check("rst_illegal", {31'b0, id_illegal}, 32'd0);
    check("rst_pc", id_pc, 32'd0);
    check("rst_opcode", {25'b0, id_opcode}, 32'h13);
    @(negedge clk);
    rst_n = 1'b1;

    // Single transfer, one-cycle latency
    if_valid = 1'b1; if_instr = 32'hFFC0_8093; if_pc = 32'h100; id_ready = 1'b1;
    tick();
    if_valid = 1'b0;
    check("t1_id_valid", {31'b0, id_valid}, 32'd1);
    check("t1_imm_src", {29'b0, id_imm_src}, 32'd0);
    check("t1_imm_inst", {7'b0, id_imm_inst}, 32'h01FF_8101);
    check("t1_rd", {27'b0, id_rd}, 32'd1);
    check("t1_rs1", {27'b0, id_rs1}, 32'd1);
    check("t1_funct3", {29'b0, id_funct3}, 32'd0);
    check("t1_pc", id_pc, 32'h100);
    tick();
    check("t1_drained", {31'b0, id_valid}, 32'd0);

    // Backpressure: sw, beq, jal with id_ready low
    id_ready = 1'b0;
    if_valid = 1'b1; if_instr = 32'h0011_2223; if_pc = 32'h200;
    tick();
    check("bp_ready_after1", {31'b0, if_ready}, 32'd1);
    check("bp_sw_src", {29'b0, id_imm_src}, 32'd1);
    if_instr = 32'h0000_0463; if_pc = 32'h204;
    tick();
    check("bp_ready_after2", {31'b0, if_ready}, 32'd0);
    if_instr = 32'h0080_006F; if_pc = 32'h208;
    tick();
    check("bp_hold_ready", {31'b0, if_ready}, 32'd0);
    check("bp_hold_pc", id_pc, 32'h200);
    check("bp_hold_inst", {id_imm_inst, id_opcode}, 32'h0011_2223);
    id_ready = 1'b1;
    tick();
    check("bp_beq_pc", id_pc, 32'h204);
    check("bp_beq_src", {29'b0, id_imm_src}, 32'd5);
    check("bp_ready_back", {31'b0, if_ready}, 32'd1);
    tick();
    if_valid = 1'b0;
    check("bp_jal_pc", id_pc, 32'h208);
    check("bp_jal_src", {29'b0, id_imm_src}, 32'd6);
    check("bp_jal_valid", {31'b0, id_valid}, 32'd1);
    tick();
    check("bp_empty", {31'b0, id_valid}, 32'd0);

    // Flush in TWO with if_valid asserted
    id_ready = 1'b0;
    if_valid = 1'b1; if_instr = 32'hFFC0_8093; if_pc = 32'h300;
    tick();
    if_instr = 32'h1234_50B7; if_pc = 32'h304;
    tick();
    check("fl_two_ready", {31'b0, if_ready}, 32'd0);
    flush = 1'b1; if_instr = 32'h0050_0513; if_pc = 32'h308;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    check("fl_id_valid", {31'b0, id_valid}, 32'd0);
    check("fl_if_ready", {31'b0, if_ready}, 32'd1);
    check("fl_imm_src", {29'b0, id_imm_src}, 32'd0);
    check("fl_has_imm", {31'b0, id_has_imm}, 32'd1);
    check("fl_pc", id_pc, 32'd0);
    check("fl_instr_nop", {id_imm_inst, id_opcode}, NOP);
    tick();
    check("fl_no_ghost", {31'b0, id_valid}, 32'd0);

    // Flush in ONE with a real concurrent transfer-in
    if_valid = 1'b1; if_instr = 32'h0011_2223; if_pc = 32'h400;
    tick();
    flush = 1'b1; if_instr = 32'h0000_0463; if_pc = 32'h404;
    tick();
    flush = 1'b0; if_valid = 1'b0;
    check("fl1_id_valid", {31'b0, id_valid}, 32'd0);
    tick();
    check("fl1_no_ghost", {31'b0, id_valid}, 32'd0);

    // Async reset between edges while in TWO
    id_ready = 1'b0;
    if_valid = 1'b1; if_instr = 32'h0011_2223; if_pc = 32'h500;
    tick();
    if_instr = 32'h0000_0463; if_pc = 32'h504;
    tick();
    if_valid = 1'b0;
    check("ar_pre_valid", {31'b0, id_valid}, 32'd1);
    check("ar_pre_ready", {31'b0, if_ready}, 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("ar_id_valid", {31'b0, id_valid}, 32'd0);
    check("ar_if_ready", {31'b0, if_ready}, 32'd1);
    check("ar_pc", id_pc, 32'd0);
    #1 rst_n = 1'b1;
    tick();
    check("ar_still_empty", {31'b0, id_valid}, 32'd0);

    // Decode sweep
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if_valid = 1'b1; if_instr = sweep_instr[i]; if_pc = 32'h600 + 32'(i * 4);
      tick();
      if_valid = 1'b0;
      check($sformatf("sw%0d_src", i), {29'b0, id_imm_src}, {29'b0, sweep_src[i]});
      check($sformatf("sw%0d_has", i), {31'b0, id_has_imm}, {31'b0, sweep_has[i]});
      check($sformatf("sw%0d_illegal", i), {31'b0, id_illegal}, 32'd0);
      tick();
    end
    if_valid = 1'b1; if_instr = 32'h0000_000B; if_pc = 32'h700;
    tick();
    if_valid = 1'b0;
    check("ill_has_imm", {31'b0, id_has_imm}, 32'd0);
    check("ill_imm_src", {29'b0, id_imm_src}, 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("ill_flag", {31'b0, id_illegal}, 32'd1);
    check("ill_stall", {31'b0, if_ready}, 32'd0);
`else
    check("ill_flag", {31'b0, id_illegal}, 32'd0);
    check("ill_nostall", {31'b0, if_ready}, 32'd1);
`endif
    tick();
    check("ill_drained", {31'b0, id_valid}, 32'd0);
    check("ill_ready_back", {31'b0, if_ready}, 32'd1);

    // Streaming with random backpressure and scoreboard
    sent = 0; recvd = 0; cycles = 0; held = 1'b0;
    held_i = 32'h0; held_p = 32'h0;
    while (recvd < 100 && cycles < 3000) begin
      rnd = $urandom();
      if_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      if_instr = {rnd[31:7], legal_ops[$urandom_range(0, 9)]};
      if_pc    = 32'h1000 + 32'(sent * 4);
      id_ready = ($urandom_range(0, 3) != 0);
      if (held) begin
        check("st_stable_instr", {id_imm_inst, id_opcode}, held_i);
        check("st_stable_pc", id_pc, held_p);
      end
      if (id_valid && id_ready) begin
        check("st_expected_pending", {31'b0, (q_instr.size() != 0)}, 32'd1);
        if (q_instr.size() != 0) begin
          exp_i = q_instr.pop_front();
          exp_p = q_pc.pop_front();
          check("st_instr", {id_imm_inst, id_opcode}, exp_i);
          check("st_pc", id_pc, exp_p);
        end
        recvd++;
      end
      if (if_valid && if_ready) begin
        q_instr.push_back(if_instr);
        q_pc.push_back(if_pc);
        sent++;
      end
      held   = id_valid && !id_ready;
      held_i = {id_imm_inst, id_opcode};
      held_p = id_pc;
      tick();
      cycles++;
    end
    if_valid = 1'b0;
    check("st_received", recvd, 32'd100);
    check("st_sent", sent, 32'd100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
